// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared constants and types for the VGA frame-buffer path.
//   FB_W, FB_H    : frame-buffer size in words (160 x 120)
//   SCALE_LOG2    : log2 of the upscale factor (one word = 4x4 screen pixels)
//   FB_ADDR_W     : frame-buffer address width (19200 words fit in 15 bits)
//   H_ACTIVE/V_ACTIVE : visible screen size in pixels
//   rgb_t         : one frame-buffer word, {r,g,b}
// -----------------------------------------------------------------------------
package vga_pkg;
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int SCALE_LOG2 = 2;
  localparam int FB_ADDR_W  = 15;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;

  typedef logic [2:0] rgb_t;
endpackage

// File: rtl/fb_addr_gen.sv
// -----------------------------------------------------------------------------
// fb_addr_gen
// Combinational frame-buffer address: o_addr = i_row * 160 + i_col.
// The multiply by 160 is built as (row << 7) + (row << 5), so no DSP multiplier
// is needed. The result wraps at FB_ADDR_W bits; callers only rely on it for
// in-range coordinates.
// Ports:
//   i_row  in  ROW_W      word row
//   i_col  in  COL_W      word column
//   o_addr out FB_ADDR_W  linear word address
// -----------------------------------------------------------------------------
module fb_addr_gen
  import vga_pkg::*;
#(
  parameter int ROW_W = 10,
  parameter int COL_W = 10
) (
  input  logic [ROW_W-1:0]     i_row,
  input  logic [COL_W-1:0]     i_col,
  output logic [FB_ADDR_W-1:0] o_addr
);

  logic [FB_ADDR_W-1:0] w_row_ext;
  logic [FB_ADDR_W-1:0] w_col_ext;

  assign w_row_ext = FB_ADDR_W'(i_row);
  assign w_col_ext = FB_ADDR_W'(i_col);

  // 160 = 128 + 32
  assign o_addr = (w_row_ext << 7) + (w_row_ext << 5) + w_col_ext;

endmodule

// File: rtl/fb_scanout_arbiter.sv
// -----------------------------------------------------------------------------
// fb_scanout_arbiter
// Shares one single-port frame-buffer RAM between display scan-out and a host
// pixel writer. Every active pixel with pixel_x[1:0]==0 is a display slot that
// fetches one word; all other cycles belong to the writer. The fetched word is
// kept in a hold register and shown for the 4 pixels of its group, giving a
// 4x upscale of the 160x120 buffer to 640x480.
// Colour and syncs are both delayed by exactly 2 cycles.
// Ports:
//   clk                    in   pixel clock
//   rst                    in   synchronous reset, active low
//   pixel_x, pixel_y       in   coordinates from the sync generator
//   video_on               in   1 inside the active region
//   h_sync_in, v_sync_in   in   raw syncs
//   wr_valid/wr_ready      in/out writer handshake
//   wr_x, wr_y, wr_rgb     in   writer word coordinate and data
//   ram_addr/ram_we/ram_wdata out RAM request (read data 1 cycle later)
//   ram_rdata              in   RAM read data
//   h_sync, v_sync         out  delayed syncs
//   red, green, blue       out  pixel colour
// -----------------------------------------------------------------------------
module fb_scanout_arbiter
  import vga_pkg::*;
#(
  parameter int FB_W       = vga_pkg::FB_W,
  parameter int FB_H       = vga_pkg::FB_H,
  parameter int SCALE_LOG2 = vga_pkg::SCALE_LOG2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           pixel_x,
  input  logic [9:0]           pixel_y,
  input  logic                 video_on,
  input  logic                 h_sync_in,
  input  logic                 v_sync_in,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [7:0]           wr_x,
  input  logic [6:0]           wr_y,
  input  logic [2:0]           wr_rgb,
  output logic [FB_ADDR_W-1:0] ram_addr,
  output logic                 ram_we,
  output logic [2:0]           ram_wdata,
  input  logic [2:0]           ram_rdata,
  output logic                 h_sync,
  output logic                 v_sync,
  output logic                 red,
  output logic                 green,
  output logic                 blue
);

  // Index 0: display address generator, index 1: writer address generator.
  logic [9:0]           w_row  [2];
  logic [9:0]           w_col  [2];
  logic [FB_ADDR_W-1:0] w_addr [2];

  logic w_disp_slot;
  logic w_accept;
  logic w_in_range;

  logic [FB_ADDR_W-1:0] r_addr_last;
  logic                 r_von_d1;
  logic                 r_fetch_d1;
  logic                 r_hs_d1;
  logic                 r_vs_d1;
  logic                 r_hs;
  logic                 r_vs;
  rgb_t                 r_hold;
  rgb_t                 r_rgb;

  // ---------------------------------------------------------------------------
  // Slot decode and address generation
  // ---------------------------------------------------------------------------
  assign w_disp_slot = video_on && (pixel_x[SCALE_LOG2-1:0] == '0);

  assign w_row[0] = pixel_y >> SCALE_LOG2;
  assign w_col[0] = pixel_x >> SCALE_LOG2;
  assign w_row[1] = {3'b000, wr_y};
  assign w_col[1] = {2'b00, wr_x};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_addr
      fb_addr_gen #(
        .ROW_W (10),
        .COL_W (10)
      ) u_addr_gen (
        .i_row  (w_row[gi]),
        .i_col  (w_col[gi]),
        .o_addr (w_addr[gi])
      );
    end
  endgenerate

  // Ready is purely a function of the current pixel, so the writer can see it
  // in the same cycle; it never loses more than one cycle in a row.
  assign wr_ready   = rst && !w_disp_slot;
  assign w_accept   = wr_valid && wr_ready;
  assign w_in_range = (int'(wr_x) < FB_W) && (int'(wr_y) < FB_H);

  // ---------------------------------------------------------------------------
  // RAM port mux. Out-of-range writes are accepted but never strobe ram_we.
  // With no request the address is parked on its last value to avoid
  // needless toggling on the RAM address bus.
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_addr  = r_addr_last;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (!rst) begin
      ram_addr = '0;
    end else if (w_disp_slot) begin
      ram_addr = w_addr[0];
    end else if (w_accept) begin
      ram_addr  = w_addr[1];
      ram_we    = w_in_range;
      ram_wdata = wr_rgb;
    end
  end

  // ---------------------------------------------------------------------------
  // Two-stage scan-out pipeline.
  // Stage 1 registers the per-pixel flags while the RAM performs the read.
  // Stage 2 picks fresh read data on a fetch pixel, otherwise the hold word.
  // The hold register only loads on fetch cycles, so writes to RAM never
  // disturb the word currently being displayed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_addr_last <= '0;
      r_von_d1    <= 1'b0;
      r_fetch_d1  <= 1'b0;
      r_hs_d1     <= 1'b1;
      r_vs_d1     <= 1'b1;
      r_hs        <= 1'b1;
      r_vs        <= 1'b1;
      r_hold      <= '0;
      r_rgb       <= '0;
    end else begin
      r_addr_last <= ram_addr;
      r_von_d1    <= video_on;
      r_fetch_d1  <= w_disp_slot;
      r_hs_d1     <= h_sync_in;
      r_vs_d1     <= v_sync_in;
      r_hs        <= r_hs_d1;
      r_vs        <= r_vs_d1;
      if (r_fetch_d1) begin
        r_hold <= ram_rdata;
      end
      if (!r_von_d1) begin
        r_rgb <= '0;
      end else if (r_fetch_d1) begin
        r_rgb <= ram_rdata;
      end else begin
        r_rgb <= r_hold;
      end
    end
  end

  assign {red, green, blue} = r_rgb;
  assign h_sync             = r_hs;
  assign v_sync             = r_vs;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_scanout_arbiter
// Scoreboard bench: the driver applies one pixel per cycle, pushes the
// expected combinational response for that cycle and the expected colour/sync
// two cycles later; the monitor pops and compares on the falling edge.
// A behavioural RAM with 1-cycle read latency sits on the RAM port.
// -----------------------------------------------------------------------------
module tb_fb_scanout_arbiter;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, h_sync_in, v_sync_in;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [2:0]  wr_rgb;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [2:0]  ram_wdata;
  logic [2:0]  ram_rdata;
  logic        h_sync, v_sync, red, green, blue;

  always #5 clk = ~clk;

  fb_scanout_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .video_on  (video_on),
    .h_sync_in (h_sync_in),
    .v_sync_in (v_sync_in),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_rgb    (wr_rgb),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .h_sync    (h_sync),
    .v_sync    (v_sync),
    .red       (red),
    .green     (green),
    .blue      (blue)
  );

  // Initial contents: word a holds a[2:0]^3'b011, except word 1 = 3'b101.
  function automatic logic [2:0] init_word(input int a);
    logic [2:0] v;
    v = 3'(a) ^ 3'b011;
    if (a == 1) v = 3'b101;
    return v;
  endfunction

  // Behavioural single-port RAM, loaded on the first clock edge.
  logic [2:0] mem [0:32767];
  bit         mem_loaded = 1'b0;
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int a = 0; a < 32768; a++) mem[a] <= init_word(a);
      mem_loaded <= 1'b1;
      ram_rdata  <= 3'b000;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  localparam int K_RGB = 0, K_SYNC = 1, K_RDY = 2, K_WE = 3, K_ADDR = 4, K_WDATA = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [14:0] val;
  } exp_t;

  exp_t sbq[$];
  int   cyc     = 0;
  bit   mon_en  = 1'b0;
  int   n_vec   = 0;
  int   n_bad   = 0;

  function automatic string kname(input int k);
    case (k)
      K_RGB:   return "rgb";
      K_SYNC:  return "sync";
      K_RDY:   return "wr_ready";
      K_WE:    return "ram_we";
      K_ADDR:  return "ram_addr";
      default: return "ram_wdata";
    endcase
  endfunction

  function automatic logic [14:0] actual(input int k);
    case (k)
      K_RGB:   return {12'b0, red, green, blue};
      K_SYNC:  return {13'b0, h_sync, v_sync};
      K_RDY:   return {14'b0, wr_ready};
      K_WE:    return {14'b0, ram_we};
      K_ADDR:  return ram_addr;
      default: return {12'b0, ram_wdata};
    endcase
  endfunction

  task automatic push(input int c, input int k, input int v);
    exp_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = 15'(v);
    sbq.push_back(e);
  endtask

  // Reset overrides any colour/sync already scheduled from c onwards.
  task automatic purge(input int c);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].cyc >= c && (sbq[i].kind == K_RGB || sbq[i].kind == K_SYNC))
        sbq.delete(i);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc <= cyc) begin
          n_vec++;
          if (sbq[i].cyc < cyc) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: not sampled in time (now cyc %0d), required 'h%0h",
                     kname(sbq[i].kind), sbq[i].cyc, cyc, sbq[i].val);
          end else if (actual(sbq[i].kind) !== sbq[i].val) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got 'h%0h, required 'h%0h",
                     kname(sbq[i].kind), cyc, actual(sbq[i].kind), sbq[i].val);
          end else begin
            $display("ok   %s @cyc %0d: 'h%0h", kname(sbq[i].kind), cyc, sbq[i].val);
          end
          sbq.delete(i);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model state and driver
  // ---------------------------------------------------------------------------
  logic [2:0] sh [0:32767];  // expected frame-buffer contents
  logic [2:0] m_hold;
  int         m_last;

  task automatic step(input bit r, input int x, input int y, input bit von,
                      input bit hs, input bit vs, input bit wv,
                      input int wx, input int wy, input logic [2:0] wrgb);
    bit disp, rdy, acc, we;
    int a;
    rst       = r;
    pixel_x   = 10'(x);
    pixel_y   = 10'(y);
    video_on  = von;
    h_sync_in = hs;
    v_sync_in = vs;
    wr_valid  = wv;
    wr_x      = 8'(wx);
    wr_y      = 7'(wy);
    wr_rgb    = wrgb;
    if (!r) begin
      purge(cyc + 1);
      push(cyc, K_RDY, 0);
      push(cyc, K_WE, 0);
      push(cyc, K_ADDR, 0);
      push(cyc + 1, K_RGB, 0);
      push(cyc + 1, K_SYNC, 3);
      push(cyc + 2, K_RGB, 0);
      push(cyc + 2, K_SYNC, 3);
      m_hold = 3'b000;
      m_last = 0;
    end else begin
      disp = von && (x % 4 == 0);
      rdy  = !disp;
      acc  = wv && rdy;
      we   = acc && (wx < 160) && (wy < 120);
      if (disp)     a = (y / 4) * 160 + (x / 4);
      else if (acc) a = wy * 160 + wx;
      else          a = m_last;
      push(cyc, K_RDY, int'(rdy));
      push(cyc, K_WE, int'(we));
      push(cyc, K_ADDR, a);
      if (we) push(cyc, K_WDATA, int'(wrgb));
      if (von && disp) m_hold = sh[a];
      push(cyc + 2, K_RGB, von ? int'(m_hold) : 0);
      push(cyc + 2, K_SYNC, int'({hs, vs}));
      if (we) sh[a] = wrgb;
      m_last = a;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    h_sync_in = 1'b1; v_sync_in = 1'b1; wr_valid = 1'b0;
    wr_x = '0; wr_y = '0; wr_rgb = '0;
    for (int a = 0; a < 32768; a++) sh[a] = init_word(a);
    m_hold = 3'b000;
    m_last = 0;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Reset for 3 cycles with syncs toggling and a pending write request.
    for (int i = 0; i < 3; i++)
      step(1'b0, 4 * i, 0, 1'b1, (i % 2) == 1, (i % 2) == 0, 1'b1, 3, 0, 3'b111);

    // Frame 0, line 0: latency/hold on word 1, coherency writes at x=21,22.
    for (int x = 0; x < 48; x++) begin
      if (x == 0) push(cyc, K_ADDR, 0);
      if (x == 4) begin
        push(cyc, K_ADDR, 1);
        for (int k = 2; k < 6; k++) push(cyc + k, K_RGB, 3'b101);
        push(cyc + 6, K_RGB, 3'b001);
      end
      if (x == 5) push(cyc + 2, K_SYNC, 2'b01);
      if (x >= 8 && x < 12) push(cyc + 2, K_RGB, 3'b001);
      if (x >= 40 && x < 44) push(cyc + 2, K_RGB, 3'b010);
      step(1'b1, x, 0, 1'b1, (x % 8) < 4, 1'b1, (x == 21) || (x == 22),
           (x == 21) ? 10 : 2, 0, (x == 21) ? 3'b010 : 3'b110);
    end

    // Horizontal blanking: writer owns every cycle; bounds checks.
    for (int x = 640; x < 656; x++) begin
      push(cyc, K_RDY, 1);
      if (x == 641) push(cyc, K_WE, 0);
      if (x == 642) begin
        push(cyc, K_ADDR, 19199);
        push(cyc, K_WE, 1);
        push(cyc, K_WDATA, 3'b010);
      end
      step(1'b1, x, 0, 1'b0, !(x >= 644 && x < 650), x < 652, (x == 641) || (x == 642),
           (x == 641) ? 160 : 159, (x == 641) ? 5 : 119, 3'b010);
    end

    // Address mapping: pixel (4,4) -> word 161.
    for (int x = 4; x < 8; x++) begin
      if (x == 4) push(cyc, K_ADDR, 161);
      step(1'b1, x, 4, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000);
    end

    // Last group of the screen -> word 19199, written green above.
    for (int x = 636; x < 640; x++) begin
      if (x == 636) begin
        push(cyc, K_ADDR, 19199);
        for (int k = 2; k < 6; k++) push(cyc + k, K_RGB, 3'b010);
      end
      step(1'b1, x, 479, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000);
    end

    // Arbitration: writer asserts valid through an active line.
    for (int x = 0; x < 32; x++) begin
      push(cyc, K_RDY, int'((x % 4) != 0));
      step(1'b1, x, 8, 1'b1, 1'b1, 1'b1, 1'b1, x, 100, 3'(x));
    end
    for (int i = 0; i < 4; i++)
      step(1'b1, 700, 8, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000);

    // Reset mid-line with a write to word 0 pending: write must not happen.
    push(cyc, K_WE, 0);
    step(1'b0, 13, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 3'b111);
    step(1'b0, 14, 0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 3'b111);

    // Mid-group entry after reset shows the cleared hold word.
    for (int x = 1; x < 4; x++) begin
      push(cyc + 2, K_RGB, 3'b000);
      step(1'b1, x, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000);
    end

    // Frame 1, line 0: word 0 untouched, word 2 now shows its new value.
    for (int x = 0; x < 48; x++) begin
      if (x == 0) begin
        push(cyc, K_ADDR, 0);
        push(cyc + 2, K_RGB, 3'b011);
      end
      if (x >= 8 && x < 12) push(cyc + 2, K_RGB, 3'b110);
      if (x >= 40 && x < 44) push(cyc + 2, K_RGB, 3'b010);
      step(1'b1, x, 0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000);
    end
    for (int i = 0; i < 2; i++)
      step(1'b1, 700, 0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 3'b000);

    // Drain the pipeline without scheduling new checks.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    while (sbq.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s @cyc %0d: never compared, required 'h%0h",
               kname(sbq[0].kind), sbq[0].cyc, sbq[0].val);
      void'(sbq.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
